// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch compare, EX/MEM register.
// Define EX_MUL_EN to build the iterative shift-add multiplier (op 9) and its stall FSM.
module ex_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [5:0]            i_alu_mode,
  input  logic [DATA_W-1:0]     i_op_a,
  input  logic [DATA_W-1:0]     i_op_b,
  input  logic [DATA_W-1:0]     i_imm,
  input  logic [REG_ADDR_W-1:0] i_src1,
  input  logic [REG_ADDR_W-1:0] i_src2,
  input  logic [REG_ADDR_W-1:0] i_write_reg,
  input  logic                  i_reg_write,
  input  logic                  i_mem_to_reg,
  input  logic                  i_mem_write,
  input  logic                  i_mem_read,
  input  logic                  i_branch,
  input  logic                  i_fwd_mem_we,
  input  logic [REG_ADDR_W-1:0] i_fwd_mem_reg,
  input  logic [DATA_W-1:0]     i_fwd_mem_data,
  input  logic                  i_fwd_wb_we,
  input  logic [REG_ADDR_W-1:0] i_fwd_wb_reg,
  input  logic [DATA_W-1:0]     i_fwd_wb_data,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic [DATA_W-1:0]     o_alu_result,
  output logic [DATA_W-1:0]     o_store_data,
  output logic [REG_ADDR_W-1:0] o_write_reg,
  output logic                  o_reg_write,
  output logic                  o_mem_to_reg,
  output logic                  o_mem_write,
  output logic                  o_mem_read,
  output logic                  o_branch_taken
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  logic [3:0]        op;
  logic [DATA_W-1:0] fwd_a, fwd_b, opnd_b, alu_res, res_sel;
  logic [SH_W-1:0]   shamt;
  logic              unused_mode;

  assign op          = i_alu_mode[3:0];
  assign unused_mode = i_alu_mode[4];

  // EX/MEM candidate is younger than MEM/WB, so it wins; r0 is never forwarded.
  always_comb begin
    fwd_a = i_op_a;
    if (i_fwd_mem_we && i_fwd_mem_reg == i_src1 && i_src1 != '0)
      fwd_a = i_fwd_mem_data;
    else if (i_fwd_wb_we && i_fwd_wb_reg == i_src1 && i_src1 != '0)
      fwd_a = i_fwd_wb_data;

    fwd_b = i_op_b;
    if (i_fwd_mem_we && i_fwd_mem_reg == i_src2 && i_src2 != '0)
      fwd_b = i_fwd_mem_data;
    else if (i_fwd_wb_we && i_fwd_wb_reg == i_src2 && i_src2 != '0)
      fwd_b = i_fwd_wb_data;
  end

  assign opnd_b = i_alu_mode[5] ? i_imm : fwd_b;
  assign shamt  = opnd_b[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD: alu_res = fwd_a + opnd_b;
      OP_SUB: alu_res = fwd_a - opnd_b;
      OP_AND: alu_res = fwd_a & opnd_b;
      OP_OR:  alu_res = fwd_a | opnd_b;
      OP_XOR: alu_res = fwd_a ^ opnd_b;
      OP_SLL: alu_res = fwd_a << shamt;
      OP_SRL: alu_res = fwd_a >> shamt;
      OP_SRA: alu_res = $signed(fwd_a) >>> shamt;
      OP_SLT: alu_res[0] = $signed(fwd_a) < $signed(opnd_b);
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MUL_EN
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [SH_W-1:0]   cnt;
  logic [DATA_W-1:0] mul_a, mul_b, acc;
  logic              mul_start;

  assign mul_start = (state == ST_IDLE) && i_valid && (op == OP_MUL);
  assign o_stall   = !rst && (mul_start || state == ST_BUSY);
  assign res_sel   = (state == ST_DONE) ? acc : alu_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      mul_a <= '0;
      mul_b <= '0;
      acc   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (mul_start) begin
          mul_a <= fwd_a;
          mul_b <= opnd_b;
          acc   <= '0;
          cnt   <= '0;
          state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (mul_b[cnt]) acc <= acc + (mul_a << cnt);
          cnt <= cnt + 1'b1;
          if (cnt == SH_W'(DATA_W - 1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  assign o_stall = 1'b0;
  assign res_sel = alu_res;
`endif

  // Data outputs still load while idle so they stay deterministic; only controls are gated.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid        <= 1'b0;
      o_alu_result   <= '0;
      o_store_data   <= '0;
      o_write_reg    <= '0;
      o_reg_write    <= 1'b0;
      o_mem_to_reg   <= 1'b0;
      o_mem_write    <= 1'b0;
      o_mem_read     <= 1'b0;
      o_branch_taken <= 1'b0;
    end else begin
      o_alu_result <= res_sel;
      o_store_data <= fwd_b;
      o_write_reg  <= i_write_reg;
      if (i_valid && !o_stall) begin
        o_valid        <= 1'b1;
        o_reg_write    <= i_reg_write;
        o_mem_to_reg   <= i_mem_to_reg;
        o_mem_write    <= i_mem_write;
        o_mem_read     <= i_mem_read;
        o_branch_taken <= i_branch && (fwd_a == fwd_b);
      end else begin
        o_valid        <= 1'b0;
        o_reg_write    <= 1'b0;
        o_mem_to_reg   <= 1'b0;
        o_mem_write    <= 1'b0;
        o_mem_read     <= 1'b0;
        o_branch_taken <= 1'b0;
      end
    end
  end

endmodule
